fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the RISC pipeline. Owns the program counter, drives the instruction-memory read address, and registers the returned word into the IF/ID pipeline register for decode. Handles the boot/program-load window, stalls, flushes, branch/jump redirects and end-of-memory halt. Sits directly upstream of the instruction memory's read port and directly upstream of decode.

## Interface
- PC_W, 64, PC and address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, first fetch address after load window
- IMEM_DEPTH, 32, instruction memory depth in words; END = IMEM_DEPTH*4
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- load_mode  in  1  program-load window active; same signal as the memory's load enable
- stall  in  1  hold PC and IF/ID (from hazard unit)
- flush  in  1  insert bubble into IF/ID, PC advances normally
- redirect_valid  in  1  taken branch/jump
- redirect_pc  in  PC_W  redirect target
- imem_addr  out  PC_W  read address to instruction memory (= pc register)
- imem_instr  in  INSTR_W  combinational read data from instruction memory
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  PC_W  PC of IF/ID instruction
- if_id_pc_plus4  out  PC_W  if_id_pc + 4
- if_id_instr  out  INSTR_W  fetched word
- halted  out  1  state == HALT
- redirect_err  out  1  sticky: bad redirect target seen
- fetch_count  out  32  instructions delivered to IF/ID

## Operation
- States: BOOT, RUN, HALT. Reset -> BOOT.
- Priority per cycle: load_mode > redirect_valid > stall > flush > sequential.
- BOOT: pc held at RESET_PC, IF/ID valid=0. load_mode low -> RUN at next edge (pc still RESET_PC).
- load_mode high in any state -> BOOT next edge, pc := RESET_PC, IF/ID cleared, fetch_count cleared, redirect_err kept.
- RUN, sequential: IF/ID := {1, pc, pc+4, imem_instr}; pc := pc+4; fetch_count += 1. If pc == END-4: capture as above, pc holds, -> HALT.
- Valid redirect (redirect_pc[1:0]==0, redirect_pc < END): pc := redirect_pc, IF/ID valid := 0 (wrong-path word discarded), state := RUN (also from HALT). Overrides stall.
- Invalid redirect: pc unchanged, IF/ID valid := 0, redirect_err := 1 (sticky until reset), state unchanged.
- stall (no redirect): pc, IF/ID, fetch_count, state all held.
- flush (no stall/redirect): pc advances as sequential, IF/ID valid := 0, fetch_count not incremented; end-of-memory HALT rule still applies.
- HALT: pc held, IF/ID valid := 0 on every non-stall cycle; exit only via valid redirect or load_mode.
- PC arithmetic modulo 2^PC_W; never reaches END by construction.
- fetch_count wraps at 2^32.

## Timing
- imem_addr combinational from pc register; instruction visible same cycle, captured at next posedge.
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=0, halted=0, redirect_err=0, fetch_count=0.
- First instruction: load_mode falls before edge N -> RUN after N; IF/ID valid with RESET_PC word after N+1.
- Redirect sampled at edge N -> pc=target after N; target word in IF/ID after N+1 (one bubble).
- Reset mid-operation asynchronously forces all reset values regardless of state.
- if_id_pc_plus4 registered, not derived combinationally at output.

## Structure
- Shared pipeline package: state enum (BOOT/RUN/HALT), IF/ID bundle typedef {valid, pc, pc_plus4, instr}, NOP/bubble constant, RESET_PC default.
- One natural sub-module: if_id_reg (registered IF/ID bundle with hold/clear controls); PC/FSM logic in fetch_unit.

## Test plan
- Reset, load_mode=1 for 5 cycles, release; memory words 0x11,0x22,0x33 -> IF/ID shows (pc 0,0x11),(4,0x22),(8,0x33) on consecutive cycles, fetch_count=3.
- stall held 3 cycles at pc=8 -> IF/ID, imem_addr, fetch_count frozen; resume continues at pc=12 without skip or duplicate.
- Redirect to 0x40 with stall=1 same cycle -> pc=0x40 next cycle, one bubble, then (0x40, mem[16]) valid.
- Redirect to 0x42 and to 0x80 (END=0x80) -> redirect_err=1, pc unchanged, one bubble each, state RUN.
- Run sequentially to pc=0x7C -> word captured, halted=1, thereafter if_id_valid=0; redirect 0x0 -> RUN, halted=0.
- Assert load_mode mid-RUN at pc=0x20 -> BOOT, pc=0, IF/ID cleared, fetch_count=0; async rst_n pulse mid-cycle -> all reset values immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types for the fetch stage: FSM states, IF/ID bundle, bubble constant.
package fetch_unit_pkg;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} fetch_state_e;

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  // Empty IF/ID slot; all-zero so a bubble matches the reset image
  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: '0};
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs, instruction-memory read port, IF/ID and status outputs.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               load_mode;
  logic               stall;
  logic               flush;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               if_id_valid;
  logic [PC_W-1:0]    if_id_pc;
  logic [PC_W-1:0]    if_id_pc_plus4;
  logic [INSTR_W-1:0] if_id_instr;
  logic               halted;
  logic               redirect_err;
  logic [31:0]        fetch_count;

  modport master (
    input  load_mode, stall, flush, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
           halted, redirect_err, fetch_count
  );

  modport slave (
    output load_mode, stall, flush, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr,
           halted, redirect_err, fetch_count
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: clear wins over hold, otherwise loads the new bundle.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold_i,
  input  logic   clear_i,
  input  if_id_t d_i,
  output if_id_t q_o
);
  if_id_t q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       q_q <= IF_ID_BUBBLE;
    else if (clear_i) q_q <= IF_ID_BUBBLE;
    else if (!hold_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, BOOT/RUN/HALT control, redirect checking, IF/ID capture.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              IMEM_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);
  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
  localparam logic [PC_W-1:0] END_ADDR = PC_W'(IMEM_DEPTH * 4);
  localparam logic [PC_W-1:0] LAST_PC  = END_ADDR - PC_STEP;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            ifid_hold, ifid_clear;
  if_id_t          ifid_d, ifid_q;
  logic            redir_ok;

  assign redir_ok = (bus.redirect_pc[1:0] == 2'b00) && (bus.redirect_pc < END_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Priority: load_mode > redirect > stall > per-state behaviour
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    ifid_d     = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_q + PC_STEP, instr: bus.imem_instr};
    if (bus.load_mode) begin
      state_d    = ST_BOOT;
      pc_d       = RESET_PC;
      cnt_d      = '0;
      ifid_clear = 1'b1;
    end else if (bus.redirect_valid) begin
      ifid_clear = 1'b1;
      if (redir_ok) begin
        pc_d    = bus.redirect_pc;
        state_d = ST_RUN;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.stall) begin
      ifid_hold = 1'b1;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_d    = ST_RUN;
          pc_d       = RESET_PC;
          ifid_clear = 1'b1;
        end
        ST_RUN: begin
          if (bus.flush) ifid_clear = 1'b1;
          else           cnt_d      = cnt_q + 32'd1;
          // Last word: capture it, then park on it until redirect or reload
          if (pc_q == LAST_PC) state_d = ST_HALT;
          else                 pc_d    = pc_q + PC_STEP;
        end
        ST_HALT: ifid_clear = 1'b1;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_comb begin
    bus.imem_addr      = pc_q;
    bus.halted         = (state_q == ST_HALT);
    bus.redirect_err   = err_q;
    bus.fetch_count    = cnt_q;
    bus.if_id_valid    = ifid_q.valid;
    bus.if_id_pc       = ifid_q.pc;
    bus.if_id_pc_plus4 = ifid_q.pc_plus4;
    bus.if_id_instr    = ifid_q.instr;
  end

  fetch_unit_if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (ifid_hold),
    .clear_i (ifid_clear),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );
endmodule
